// File: rtl/round_arbiter_pkg.sv
// rtl/round_arbiter_pkg.sv - shared types and widths for the posit rounding arbiter
//
// Purpose: field widths, the arbiter state enum and the request/response
// record layouts used by round_arbiter and its testbench.
package round_arbiter_pkg;

  localparam int MANT_IN_W  = 64;
  localparam int MANT_OUT_W = 32;
  localparam int K_W        = 6;
  localparam int EXP_W      = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } arb_state_e;

  typedef struct packed {
    logic [MANT_IN_W-1:0] mant;
    logic [K_W-1:0]       k;
    logic                 sign;
    logic [EXP_W-1:0]     exp;
  } round_req_t;

  typedef struct packed {
    logic [MANT_OUT_W-1:0] mant;
    logic [K_W-1:0]        k;
    logic                  sign;
    logic [EXP_W-1:0]      exp;
    logic                  err;
  } round_rsp_t;

endpackage

// File: rtl/round_arbiter_rr_arb2.sv
// rtl/round_arbiter_rr_arb2.sv - two-way round-robin grant
//
// Purpose: pick one of two requesters; on a tie the channel that was not
// granted last wins.
// Ports:
//   valid0_i, valid1_i : request present on channel 0 / 1
//   last_grant_i       : channel index granted most recently
//   gnt_o              : one-hot grant (bit N = channel N), zero if no request
module rr_arb2 (
  input  logic       valid0_i,
  input  logic       valid1_i,
  input  logic       last_grant_i,
  output logic [1:0] gnt_o
);

  always_comb begin
    gnt_o = 2'b00;
    if (valid0_i && valid1_i) begin
      gnt_o = last_grant_i ? 2'b01 : 2'b10;
    end else begin
      gnt_o = {valid1_i, valid0_i};
    end
  end

endmodule

// File: rtl/round_arbiter.sv
// rtl/round_arbiter.sv - shares one posit rounding unit between two requesters
//
// Purpose: accepts one rounding request at a time from channel 0 (multiplier)
// or channel 1 (adder), pulses the rounding unit, waits for done (or a
// watchdog timeout) and returns the result on the granted response channel.
// Ports:
//   clk, rst_n                   : clock, asynchronous active-low reset
//   reqN_valid/ready/mant/k/sign/exp : request channel N (ready is combinational)
//   rspN_valid/ready             : response handshake for channel N
//   rsp_mant/k/sign/exp/err      : shared response fields (err = watchdog fired)
//   ru_start, ru_mant/k/sign/exp : operands and start pulse to the rounding unit
//   ru_mant_out/k_final/sign_final/exp_final, ru_done : rounding unit result
//   busy                         : a transaction is in flight
module round_arbiter
  import round_arbiter_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16,
  parameter bit PRIO_RESET     = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req0_valid,
  input  logic                  req1_valid,
  output logic                  req0_ready,
  output logic                  req1_ready,
  input  logic [MANT_IN_W-1:0]  req0_mant,
  input  logic [MANT_IN_W-1:0]  req1_mant,
  input  logic [K_W-1:0]        req0_k,
  input  logic [K_W-1:0]        req1_k,
  input  logic                  req0_sign,
  input  logic                  req1_sign,
  input  logic [EXP_W-1:0]      req0_exp,
  input  logic [EXP_W-1:0]      req1_exp,
  output logic                  rsp0_valid,
  output logic                  rsp1_valid,
  input  logic                  rsp0_ready,
  input  logic                  rsp1_ready,
  output logic [MANT_OUT_W-1:0] rsp_mant,
  output logic [K_W-1:0]        rsp_k,
  output logic                  rsp_sign,
  output logic [EXP_W-1:0]      rsp_exp,
  output logic                  rsp_err,
  output logic                  ru_start,
  output logic [MANT_IN_W-1:0]  ru_mant,
  output logic [K_W-1:0]        ru_k,
  output logic                  ru_sign,
  output logic [EXP_W-1:0]      ru_exp,
  input  logic [MANT_OUT_W-1:0] ru_mant_out,
  input  logic [K_W-1:0]        ru_k_final,
  input  logic                  ru_sign_final,
  input  logic [EXP_W-1:0]      ru_exp_final,
  input  logic                  ru_done,
  output logic                  busy
);

  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_MAX  = WD_W'(TIMEOUT_CYCLES);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

  arb_state_e       state_q;
  logic             last_grant_q;
  logic             grant_q;
  logic             start_q;
  logic [1:0]       rsp_valid_q;
  logic [WD_W-1:0]  wd_q;
  logic [WD_W-1:0]  wd_d;
  round_req_t       ru_req_q;
  round_rsp_t       rsp_q;

  logic [1:0]       gnt;
  logic             idle;
  logic             rsp_ack;
  round_req_t       req_sel;

  rr_arb2 u_rr_arb2 (
    .valid0_i     (req0_valid),
    .valid1_i     (req1_valid),
    .last_grant_i (last_grant_q),
    .gnt_o        (gnt)
  );

  assign idle       = (state_q == ST_IDLE);
  assign req0_ready = idle && gnt[0];
  assign req1_ready = idle && gnt[1];

  assign req_sel = gnt[1] ? round_req_t'{req1_mant, req1_k, req1_sign, req1_exp}
                          : round_req_t'{req0_mant, req0_k, req0_sign, req0_exp};

  // Only the granted channel's ready can release the response.
  assign rsp_ack = grant_q ? rsp1_ready : rsp0_ready;

  // Saturating so a stuck count can never wrap back into range.
  assign wd_d = (wd_q == WD_MAX) ? wd_q : wd_q + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      last_grant_q <= PRIO_RESET;
      grant_q      <= 1'b0;
      start_q      <= 1'b0;
      rsp_valid_q  <= 2'b00;
      wd_q         <= '0;
      ru_req_q     <= '0;
      rsp_q        <= '0;
    end else begin
      start_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (|gnt) begin
            ru_req_q     <= req_sel;
            grant_q      <= gnt[1];
            last_grant_q <= gnt[1];
            start_q      <= 1'b1;
            state_q      <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          state_q <= ST_WAIT;
        end
        ST_WAIT: begin
          wd_q <= wd_d;
          // done wins over a timeout landing on the same cycle
          if (ru_done) begin
            rsp_q       <= '{mant: ru_mant_out, k: ru_k_final, sign: ru_sign_final,
                             exp: ru_exp_final, err: 1'b0};
            rsp_valid_q <= grant_q ? 2'b10 : 2'b01;
            state_q     <= ST_RESP;
          end else if (wd_q >= WD_LAST) begin
            rsp_q       <= '{mant: '0, k: '0, sign: 1'b0, exp: '0, err: 1'b1};
            rsp_valid_q <= grant_q ? 2'b10 : 2'b01;
            state_q     <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (rsp_ack) begin
            rsp_valid_q <= 2'b00;
            wd_q        <= '0;
            state_q     <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign ru_start   = start_q;
  assign ru_mant    = ru_req_q.mant;
  assign ru_k       = ru_req_q.k;
  assign ru_sign    = ru_req_q.sign;
  assign ru_exp     = ru_req_q.exp;
  assign rsp0_valid = rsp_valid_q[0];
  assign rsp1_valid = rsp_valid_q[1];
  assign rsp_mant   = rsp_q.mant;
  assign rsp_k      = rsp_q.k;
  assign rsp_sign   = rsp_q.sign;
  assign rsp_exp    = rsp_q.exp;
  assign rsp_err    = rsp_q.err;
  assign busy       = !idle;

endmodule

// File: tb/tb_round_arbiter.sv
// tb/tb_round_arbiter.sv - self-checking bench for round_arbiter
module tb_round_arbiter;
  import round_arbiter_pkg::*;

  localparam int TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0_valid, req1_valid, req0_ready, req1_ready;
  logic [63:0] req0_mant, req1_mant;
  logic [5:0]  req0_k, req1_k;
  logic        req0_sign, req1_sign;
  logic [2:0]  req0_exp, req1_exp;
  logic        rsp0_valid, rsp1_valid, rsp0_ready, rsp1_ready;
  logic [31:0] rsp_mant;
  logic [5:0]  rsp_k;
  logic        rsp_sign;
  logic [2:0]  rsp_exp;
  logic        rsp_err;
  logic        ru_start;
  logic [63:0] ru_mant;
  logic [5:0]  ru_k;
  logic        ru_sign;
  logic [2:0]  ru_exp;
  logic [31:0] ru_mant_out;
  logic [5:0]  ru_k_final;
  logic        ru_sign_final;
  logic [2:0]  ru_exp_final;
  logic        ru_done;
  logic        busy;

  int checks = 0;
  int errors = 0;
  int model_last = 1;

  always #5 clk = ~clk;

  round_arbiter #(.TIMEOUT_CYCLES(TIMEOUT), .PRIO_RESET(1'b1)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req1_valid(req1_valid),
    .req0_ready(req0_ready), .req1_ready(req1_ready),
    .req0_mant(req0_mant), .req1_mant(req1_mant),
    .req0_k(req0_k), .req1_k(req1_k),
    .req0_sign(req0_sign), .req1_sign(req1_sign),
    .req0_exp(req0_exp), .req1_exp(req1_exp),
    .rsp0_valid(rsp0_valid), .rsp1_valid(rsp1_valid),
    .rsp0_ready(rsp0_ready), .rsp1_ready(rsp1_ready),
    .rsp_mant(rsp_mant), .rsp_k(rsp_k), .rsp_sign(rsp_sign), .rsp_exp(rsp_exp),
    .rsp_err(rsp_err),
    .ru_start(ru_start), .ru_mant(ru_mant), .ru_k(ru_k), .ru_sign(ru_sign), .ru_exp(ru_exp),
    .ru_mant_out(ru_mant_out), .ru_k_final(ru_k_final), .ru_sign_final(ru_sign_final),
    .ru_exp_final(ru_exp_final), .ru_done(ru_done),
    .busy(busy)
  );

  logic [185:0] all_out;
  assign all_out = {req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_mant, rsp_k,
                    rsp_sign, rsp_exp, rsp_err, ru_start, ru_mant, ru_k, ru_sign,
                    ru_exp, busy, 43'd0};

  function automatic round_req_t rand_req();
    round_req_t r;
    r.mant = {$urandom, $urandom};
    r.k    = 6'($urandom_range(0, 63));
    r.sign = 1'($urandom_range(0, 1));
    r.exp  = 3'($urandom_range(0, 7));
    return r;
  endfunction

  // One full transaction. Starts and ends at posedge+1.
  // dly: cycles from ru_start to ru_done (outside 1..TIMEOUT means never).
  task automatic run_txn(input bit v0, input bit v1, input round_req_t r0,
                         input round_req_t r1, input int dly, input int bp);
    int exp_ch;
    int exp_cyc;
    int cyc;
    bit seen;
    bit to;
    round_req_t sel;
    round_rsp_t exp_rsp;
    round_rsp_t held;
    if (v0 && v1) exp_ch = (model_last == 0) ? 1 : 0;
    else          exp_ch = v1 ? 1 : 0;
    model_last = exp_ch;
    sel = (exp_ch == 1) ? r1 : r0;
    to = !(dly >= 1 && dly <= TIMEOUT);
    exp_cyc = to ? TIMEOUT + 2 : dly + 2;
    exp_rsp = '0;
    exp_rsp.err = to;

    {req0_mant, req0_k, req0_sign, req0_exp} = r0;
    {req1_mant, req1_k, req1_sign, req1_exp} = r1;
    req0_valid = v0;
    req1_valid = v1;
    #1;
    checks++;
    if ({req1_ready, req0_ready} !== ((exp_ch == 1) ? 2'b10 : 2'b01)) begin
      errors++;
      $display("FAIL grant: ready=%b expected ch%0d", {req1_ready, req0_ready}, exp_ch);
    end
    @(posedge clk); #1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    cyc = 1;
    checks++;
    if (ru_start !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL issue: ru_start=%b busy=%b expected 1 1", ru_start, busy);
    end
    checks++;
    if ({ru_mant, ru_k, ru_sign, ru_exp} !== sel) begin
      errors++;
      $display("FAIL operands: got %h expected %h", {ru_mant, ru_k, ru_sign, ru_exp}, sel);
    end

    seen = 1'b0;
    while (!seen && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
      ru_done = 1'b0;
      ru_mant_out   = $urandom;
      ru_k_final    = 6'($urandom_range(0, 63));
      ru_sign_final = 1'($urandom_range(0, 1));
      ru_exp_final  = 3'($urandom_range(0, 7));
      if (rsp0_valid || rsp1_valid) begin
        seen = 1'b1;
      end else begin
        checks++;
        if (ru_start !== 1'b0) begin
          errors++;
          $display("FAIL start_pulse: ru_start=%b at cycle %0d expected 0", ru_start, cyc);
        end
        if (!to && cyc == dly + 1) begin
          ru_done = 1'b1;
          exp_rsp = '{mant: ru_mant_out, k: ru_k_final, sign: ru_sign_final,
                      exp: ru_exp_final, err: 1'b0};
        end
      end
    end
    ru_done = 1'b0;

    checks++;
    if (!seen || cyc != exp_cyc) begin
      errors++;
      $display("FAIL latency: response at cycle %0d (seen=%0d) expected %0d", cyc, seen, exp_cyc);
    end
    checks++;
    if ({rsp1_valid, rsp0_valid} !== ((exp_ch == 1) ? 2'b10 : 2'b01)) begin
      errors++;
      $display("FAIL rsp_channel: valid=%b expected ch%0d", {rsp1_valid, rsp0_valid}, exp_ch);
    end
    checks++;
    if ({rsp_mant, rsp_k, rsp_sign, rsp_exp, rsp_err} !== exp_rsp) begin
      errors++;
      $display("FAIL rsp_data: got %h expected %h",
               {rsp_mant, rsp_k, rsp_sign, rsp_exp, rsp_err}, exp_rsp);
    end
    checks++;
    if ({ru_mant, ru_k, ru_sign, ru_exp} !== sel) begin
      errors++;
      $display("FAIL operand_hold: got %h expected %h", {ru_mant, ru_k, ru_sign, ru_exp}, sel);
    end

    held = exp_rsp;
    for (int i = 0; i < bp; i++) begin
      req0_valid = 1'b1;
      req1_valid = 1'b1;
      #1;
      checks++;
      if (req0_ready !== 1'b0 || req1_ready !== 1'b0 ||
          {rsp1_valid, rsp0_valid} !== ((exp_ch == 1) ? 2'b10 : 2'b01) ||
          {rsp_mant, rsp_k, rsp_sign, rsp_exp, rsp_err} !== held) begin
        errors++;
        $display("FAIL backpressure: cycle %0d ready=%b valid=%b data=%h expected data %h",
                 i, {req1_ready, req0_ready}, {rsp1_valid, rsp0_valid},
                 {rsp_mant, rsp_k, rsp_sign, rsp_exp, rsp_err}, held);
      end
      @(posedge clk); #1;
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;

    if (exp_ch == 1) rsp1_ready = 1'b1;
    else             rsp0_ready = 1'b1;
    @(posedge clk); #1;
    rsp0_ready = 1'b0;
    rsp1_ready = 1'b0;
    checks++;
    if (busy !== 1'b0 || rsp0_valid !== 1'b0 || rsp1_valid !== 1'b0) begin
      errors++;
      $display("FAIL release: busy=%b valid=%b expected 0 00", busy, {rsp1_valid, rsp0_valid});
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    checks++;
    if (all_out !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got %h expected 0", all_out);
    end
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_last = 1;
    @(posedge clk); #1;
  endtask

  task automatic test_single();
    round_req_t r0;
    r0 = '{mant: 64'h3FFF_FFFF_C000_0000, k: 6'd2, sign: 1'b1, exp: 3'd5};
    run_txn(1'b1, 1'b0, r0, rand_req(), 4, 0);
  endtask

  task automatic test_simultaneous();
    // called right after reset: expected order 0, 1, then 0, 1 again
    for (int i = 0; i < 4; i++) begin
      run_txn(1'b1, 1'b1, rand_req(), rand_req(), 4, 0);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 12; i++) begin
      bit v0;
      bit v1;
      v0 = 1'($urandom_range(0, 1));
      v1 = 1'($urandom_range(0, 1));
      if (!v0 && !v1) v0 = 1'b1;
      run_txn(v0, v1, rand_req(), rand_req(), int'($urandom_range(1, TIMEOUT)),
              int'($urandom_range(0, 3)));
    end
  endtask

  task automatic test_backpressure();
    run_txn(1'b0, 1'b1, rand_req(), rand_req(), 4, 10);
  endtask

  task automatic test_timeout();
    run_txn(1'b1, 1'b0, rand_req(), rand_req(), -1, 0);
    run_txn(1'b1, 1'b0, rand_req(), rand_req(), 4, 0);
    run_txn(1'b0, 1'b1, rand_req(), rand_req(), TIMEOUT, 0);
  endtask

  task automatic test_stray_done();
    ru_done = 1'b1;
    @(posedge clk); #1;
    ru_done = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0 || rsp0_valid !== 1'b0 || rsp1_valid !== 1'b0 || ru_start !== 1'b0) begin
      errors++;
      $display("FAIL stray_done: busy=%b valid=%b start=%b expected all 0",
               busy, {rsp1_valid, rsp0_valid}, ru_start);
    end
  endtask

  task automatic test_reset_mid_wait();
    round_req_t r;
    bit bad;
    r = rand_req();
    {req0_mant, req0_k, req0_sign, req0_exp} = r;
    req0_valid = 1'b1;
    @(posedge clk); #1;
    req0_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if (all_out !== '0) begin
      errors++;
      $display("FAIL reset_mid_wait: got %h expected 0", all_out);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_last = 1;
    bad = 1'b0;
    for (int i = 0; i < 10; i++) begin
      ru_done = (i == 2);
      @(posedge clk); #1;
      if (rsp0_valid || rsp1_valid || busy) bad = 1'b1;
    end
    ru_done = 1'b0;
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL no_rsp_after_reset: response or busy seen, expected none");
    end
    run_txn(1'b1, 1'b0, rand_req(), rand_req(), 4, 0);
  endtask

  initial begin
    rst_n = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_mant = '0; req1_mant = '0; req0_k = '0; req1_k = '0;
    req0_sign = 1'b0; req1_sign = 1'b0; req0_exp = '0; req1_exp = '0;
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    ru_mant_out = '0; ru_k_final = '0; ru_sign_final = 1'b0; ru_exp_final = '0;
    ru_done = 1'b0;
    @(posedge clk); #1;
    test_reset();
    test_simultaneous();
    test_single();
    test_backpressure();
    test_timeout();
    test_stray_done();
    test_random();
    test_reset_mid_wait();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/round_arbiter.md
Name: round_arbiter

Overview:
- Shares one posit rounding unit between two requesters (channel 0 = multiplier path, channel 1 = adder path).
- Per channel: accepts a shifted mantissa plus regime k, sign and exponent over a valid/ready handshake.
- Pulses the rounding unit's start, waits for its done pulse, and returns the rounded result on the matching response channel.
- Arbitration is round-robin; a watchdog recovers from a rounding unit that never signals done.

Parameters:
- TIMEOUT_CYCLES, 16, max cycles in WAIT before the watchdog fires (must be >= 8).
- PRIO_RESET, 1, channel treated as last-granted after reset, so channel 0 wins the first tie.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req0_valid / req1_valid  in  1  request present
- req0_ready / req1_ready  out  1  request accepted this cycle
- req0_mant / req1_mant  in  64  shifted mantissa
- req0_k / req1_k  in  6  regime k, two's complement
- req0_sign / req1_sign  in  1  sign
- req0_exp / req1_exp  in  3  exponent
- rsp0_valid / rsp1_valid  out  1  result available
- rsp0_ready / rsp1_ready  in  1  result consumed
- rsp_mant  out  32  rounded mantissa (shared by both channels)
- rsp_k  out  6  final k
- rsp_sign  out  1  final sign
- rsp_exp  out  3  final exponent
- rsp_err  out  1  result invalid: watchdog expired
- ru_start  out  1  one-cycle start pulse to the rounding unit
- ru_mant  out  64  operand to the rounding unit
- ru_k  out  6  operand to the rounding unit
- ru_sign  out  1  operand to the rounding unit
- ru_exp  out  3  operand to the rounding unit
- ru_mant_out  in  32  result from the rounding unit
- ru_k_final  in  6  result from the rounding unit
- ru_sign_final  in  1  result from the rounding unit
- ru_exp_final  in  3  result from the rounding unit
- ru_done  in  1  one-cycle done pulse from the rounding unit
- busy  out  1  FSM not in IDLE

Behaviour:
- Reset values: every output 0, FSM in IDLE, last_grant = PRIO_RESET, watchdog = 0. Reset is asynchronous; asserted mid-operation it abandons the transaction, and no response is produced for it.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If exactly one reqN_valid is high, grant that channel. If both are high, grant the channel that is not last_grant.
  - reqN_ready is combinational, high only in IDLE for the granted channel.
  - On the accepting edge: latch the operands into ru_mant/k/sign/exp, record the grant, update last_grant, go to ISSUE.
- ISSUE (exactly 1 cycle):
  - ru_start = 1 (registered, so high only this cycle). Then go to WAIT.
  - ru_* operands are held constant from ISSUE until the WAIT exit.
- WAIT:
  - Watchdog increments each cycle.
  - On ru_done = 1: capture ru_mant_out/k_final/sign_final/exp_final into the rsp_* registers, rsp_err = 0, go to RESP.
  - If the watchdog reaches TIMEOUT_CYCLES with no done: rsp_mant = 0, rsp_k = 0, rsp_sign = 0, rsp_exp = 0, rsp_err = 1, go to RESP.
  - A ru_done arriving on the same cycle as timeout takes priority: valid result, err = 0.
- RESP:
  - rspN_valid = 1 for the granted channel only; the other channel's valid stays 0.
  - Hold all rsp_* fields until rspN_ready = 1, then go to IDLE, clear rspN_valid and the watchdog.
  - New requests are not accepted while in RESP (no overlap; one transaction in flight).
- Nominal timing (the rounding unit's done arrives 4 cycles after start):
  - Accept at cycle 0, ru_start at cycle 1, ru_done at cycle 5, rsp_valid from cycle 6.
  - Minimum request-to-request spacing is 7 cycles with rsp_ready tied high.
- Stray inputs:
  - ru_done outside WAIT is ignored.
  - reqN_valid deasserted before acceptance is legal: nothing is granted.
- busy = (state != IDLE).
- Width rules: fields pass through unmodified; the block does no arithmetic except the watchdog counter (clog2(TIMEOUT_CYCLES+1) bits, saturating).

Decomposition:
- Shared posit package holds:
  - the state enum for arbiter states IDLE/ISSUE/WAIT/RESP (2-bit);
  - width constants MANT_IN_W = 64, MANT_OUT_W = 32, K_W = 6, EXP_W = 3;
  - a packed struct round_req_t {mant, k, sign, exp} and round_rsp_t {mant, k, sign, exp, err}.
- Sub-module: rr_arb2, a 2-way round-robin grant from {valid0, valid1, last_grant}.
- The rounding unit itself is instantiated by the parent, not inside this block.

Test Plan:
- Single request: req0 with mant = 64'h3FFF_FFFF_C000_0000, k = 6'd2, sign = 1, exp = 3'd5, and a model rounding unit with done 4 cycles after start -> req0_ready at cycle 0, ru_start only at cycle 1, rsp0_valid at cycle 6 carrying the model's outputs, err = 0, rsp1_valid stays 0.
- Simultaneous requests from reset: req0 and req1 valid at cycle 0 -> channel 0 granted first; channel 1 is granted at the first IDLE after rsp0 is consumed. Repeating the pair alternates the grant 1, 0.
- Backpressure: hold rsp1_ready = 0 for 10 cycles -> rsp1 fields stable, req0_ready stays 0 throughout, and IDLE is entered the cycle after rsp1_ready = 1.
- Timeout: model never asserts done -> after TIMEOUT_CYCLES = 16 in WAIT, rsp_valid with err = 1 and all data fields 0; the next request then completes normally with err = 0.
- Done coincident with timeout: done pulse on watchdog cycle 16 -> err = 0 and captured data is correct.
- Reset mid-WAIT: drop rst_n at cycle 3 -> all outputs 0 immediately, no rsp_valid afterward, and a fresh req0 after release completes in 6 cycles.
